// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - Iterative AES InvSubBytes stage, BPC bytes substituted per clock
//
// Purpose: applies the FIPS-197 inverse S-box to all 16 bytes of a 128-bit
// decryption state over NC = 16/BPC cycles, sharing BPC S-box lookups.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din        state from invShiftRows, byte i = din[8i+7:8i]
//   in_valid   din valid
//   in_ready   block can accept din this cycle
//   dout       substituted state (partially substituted outside DONE)
//   out_valid  dout valid
//   out_ready  downstream accepts dout
//   busy       high while bytes are being substituted

module inv_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   assign y_o = INV_SBOX[a_i];
endmodule

module inv_sub_bytes_iter #(
   parameter int BPC = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] din,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [127:0] dout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);
   localparam int NC = 16 / BPC;
   localparam int CW = (NC > 1) ? $clog2(NC) : 1;

   if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16) begin : g_bad_bpc
      $error("inv_sub_bytes_iter: BPC must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e          state_q;
   logic [127:0]    st_q;
   logic [127:0]    st_d;
   logic [CW-1:0]   cnt_q;
   logic            out_valid_q;
   logic            busy_q;

   logic [3:0]      byte_idx [BPC];
   logic [7:0]      sb_in    [BPC];
   logic [7:0]      sb_out   [BPC];

   // Byte lane k of this cycle covers state byte cnt*BPC+k (ascending order).
   always_comb begin
      for (int k = 0; k < BPC; k++) begin
         byte_idx[k] = 4'(int'(cnt_q) * BPC + k);
         sb_in[k]    = st_q[{byte_idx[k], 3'b000} +: 8];
      end
   end

   for (genvar k = 0; k < BPC; k++) begin : g_sbox
      inv_sbox u_inv_sbox (
         .a_i (sb_in[k]),
         .y_o (sb_out[k])
      );
   end

   always_comb begin
      st_d = st_q;
      for (int k = 0; k < BPC; k++) begin
         st_d[{byte_idx[k], 3'b000} +: 8] = sb_out[k];
      end
   end

   // In DONE the slot frees on the same edge the result is taken.
   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign dout      = st_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         st_q        <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  st_q    <= din;
                  cnt_q   <= '0;
                  state_q <= BUSY;
                  busy_q  <= 1'b1;
               end
            end
            BUSY: begin
               st_q  <= st_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(NC - 1)) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (in_valid) begin
                     st_q    <= din;
                     cnt_q   <= '0;
                     state_q <= BUSY;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - Directed self-checking bench for inv_sub_bytes_iter

module tb_inv_sub_bytes_iter;
   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] din;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] dout;
   logic         out_valid;
   logic         out_ready;
   logic         busy;

   logic [127:0] sw_din;
   logic         sw_valid;
   logic         sw_out_ready;
   logic [127:0] sw_dout  [4];
   logic         sw_ov    [4];
   logic         sw_ir    [4];
   logic         sw_busy  [4];

   localparam int SW_BPC [4] = '{1, 2, 8, 16};
   localparam int SW_LAT [4] = '{17, 9, 3, 2};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inv_sub_bytes_iter #(.BPC(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dout      (dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   for (genvar g = 0; g < 4; g++) begin : g_sweep
      inv_sub_bytes_iter #(.BPC(SW_BPC[g])) u_dut (
         .clk       (clk),
         .rst       (rst),
         .din       (sw_din),
         .in_valid  (sw_valid),
         .in_ready  (sw_ir[g]),
         .dout      (sw_dout[g]),
         .out_valid (sw_ov[g]),
         .out_ready (sw_out_ready),
         .busy      (sw_busy[g])
      );
   end

   typedef struct {
      logic [127:0] din;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Called #1 after a rising edge with the DUT idle; leaves it in DONE.
   // lat counts the accept cycle, so BPC=4 gives 5.
   task automatic run_block(input logic [127:0] d, output logic [127:0] got,
                            output int lat, output int bcnt);
      int edges;
      got  = '0;
      lat  = 0;
      bcnt = 0;
      din      = d;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      din      = ~d;
      if (busy) bcnt++;
      edges = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         edges++;
         if (out_valid) begin
            lat = edges + 1;
            got = dout;
            break;
         end
         if (busy) bcnt++;
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] got;
      int           lat;
      int           bcnt;
      logic         flag;
      logic [127:0] outs  [2];
      int           times [2];
      int           nout;
      int           t;
      logic [127:0] sw_got [4];
      int           sw_lat [4];

      vecs[0] = '{din: 128'h0, exp: {16{8'h52}}};
      vecs[1] = '{din: 128'h0F0E0D0C0B0A09080706050403020100,
                  exp: 128'hFBD7F3819EA340BF38A53630D56A0952};
      vecs[2] = '{din: {16{8'h63}}, exp: 128'h0};
      vecs[3] = '{din: {16{8'hED}}, exp: {16{8'h53}}};
      vecs[4] = '{din: {16{8'hFF}}, exp: {16{8'h7D}}};
      vecs[5] = '{din: {16{8'h53}}, exp: {16{8'h50}}};
      vecs[6] = '{din: {16{8'h7C}}, exp: {16{8'h01}}};
      vecs[7] = '{din: 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0,
                  exp: 128'h7D0C2155631469E126D677BA7E042B17};

      rst          = 1'b1;
      din          = '0;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      sw_din       = '0;
      sw_valid     = 1'b0;
      sw_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check_bit("reset_out_valid", out_valid, 1'b0);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_in_ready", in_ready, 1'b1);
      check("reset_dout", dout, 128'h0);

      // Table-driven vectors
      for (int i = 0; i < 8; i++) begin
         run_block(vecs[i].din, got, lat, bcnt);
         check($sformatf("vec%0d_dout", i), got, vecs[i].exp);
         check_int($sformatf("vec%0d_latency", i), lat, 5);
         check_int($sformatf("vec%0d_busy_cycles", i), bcnt, 4);
         check_bit($sformatf("vec%0d_in_ready_done", i), in_ready, 1'b0);
         pop();
         check_bit($sformatf("vec%0d_out_valid_after_pop", i), out_valid, 1'b0);
         check_bit($sformatf("vec%0d_in_ready_after_pop", i), in_ready, 1'b1);
      end

      // Backpressure: result held for 10 cycles, junk input ignored
      run_block(vecs[1].din, got, lat, bcnt);
      check("bp_dout", got, vecs[1].exp);
      flag = 1'b0;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         din      = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         if (dout !== vecs[1].exp || out_valid !== 1'b1 || in_ready !== 1'b0) flag = 1'b1;
      end
      check_bit("bp_stable", flag, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_bit("bp_release_out_valid", out_valid, 1'b0);
      check_bit("bp_release_in_ready", in_ready, 1'b1);
      check_bit("bp_release_busy", busy, 1'b0);

      // Back-to-back: second block accepted on the edge the first is taken
      din       = {16{8'h63}};
      in_valid  = 1'b1;
      out_ready = 1'b1;
      nout      = 0;
      t         = 0;
      times[0]  = 0;
      times[1]  = 0;
      outs[0]   = '1;
      outs[1]   = '1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         t++;
         if (nout == 1 && t == times[0] + 1) begin
            check_bit("b2b_second_accepted_busy", busy, 1'b1);
            check_bit("b2b_second_accepted_in_ready", in_ready, 1'b0);
         end
         if (out_valid) begin
            check_bit($sformatf("b2b_in_ready_at_out%0d", nout), in_ready, 1'b1);
            outs[nout]  = dout;
            times[nout] = t;
            nout++;
            if (nout == 1) din = {16{8'hED}};
            else in_valid = 1'b0;
            if (nout == 2) break;
         end
      end
      check_int("b2b_output_count", nout, 2);
      check("b2b_out0", outs[0], 128'h0);
      check("b2b_out1", outs[1], {16{8'h53}});
      check_int("b2b_first_latency", times[0], 5);
      check_int("b2b_spacing", times[1] - times[0], 5);
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_bit("b2b_idle_out_valid", out_valid, 1'b0);
      check_bit("b2b_idle_in_ready", in_ready, 1'b1);

      // Reset mid-operation
      din      = vecs[1].din;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_bit("midrst_out_valid", out_valid, 1'b0);
      check("midrst_dout", dout, 128'h0);
      check_bit("midrst_in_ready", in_ready, 1'b1);
      check_bit("midrst_busy", busy, 1'b0);
      flag = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) flag = 1'b1;
      end
      check_bit("midrst_no_output", flag, 1'b0);
      run_block({16{8'hFF}}, got, lat, bcnt);
      check("midrst_next_dout", got, {16{8'h7D}});
      check_int("midrst_next_latency", lat, 5);
      pop();

      // Parameter sweep on the second vector
      for (int g = 0; g < 4; g++) begin
         check_bit($sformatf("sweep_bpc%0d_in_ready", SW_BPC[g]), sw_ir[g], 1'b1);
         sw_lat[g] = 0;
         sw_got[g] = '0;
      end
      sw_din   = vecs[1].din;
      sw_valid = 1'b1;
      @(posedge clk); #1;
      sw_valid = 1'b0;
      for (int g = 0; g < 4; g++)
         check_bit($sformatf("sweep_bpc%0d_busy", SW_BPC[g]), sw_busy[g], 1'b1);
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk); #1;
         for (int g = 0; g < 4; g++) begin
            if (sw_ov[g] && sw_lat[g] == 0) begin
               sw_lat[g] = e + 1;
               sw_got[g] = sw_dout[g];
            end
         end
      end
      for (int g = 0; g < 4; g++) begin
         check($sformatf("sweep_bpc%0d_dout", SW_BPC[g]), sw_got[g], vecs[1].exp);
         check_int($sformatf("sweep_bpc%0d_latency", SW_BPC[g]), sw_lat[g], SW_LAT[g]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
- Iterative AES InvSubBytes stage for the decryption datapath.
- Consumes the 128-bit state produced by invShiftRows and applies the FIPS-197 inverse S-box to all 16 bytes.
- Processes BPC bytes per clock, so inverse S-box instances are shared across cycles.
- Uses valid/ready handshakes on input and output; its result feeds AddRoundKey.

Parameters:
- BPC, 4, bytes substituted per clock. Legal values: 1, 2, 4, 8, 16; any other value is an elaboration error. Number of processing cycles NC = 16/BPC.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- din  input  128  state from invShiftRows; byte i = din[8i+7:8i], column c = bytes 4c..4c+3
- in_valid  input  1  din valid
- in_ready  output  1  block can accept din this cycle
- dout  output  128  substituted state, same byte mapping as din
- out_valid  output  1  dout valid
- out_ready  input  1  downstream accepts dout
- busy  output  1  high in BUSY state

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, cnt=0, dout=0, out_valid=0, busy=0; in_ready=1 the cycle after reset.
- Reset mid-operation abandons the block in flight; no output is produced for it.
- Internal registers: 128-bit working register st (drives dout directly) and counter cnt of width clog2(NC), minimum 1 bit.
- Two-sided handshake: a transfer occurs on any edge where valid&ready are both high.

States:
- IDLE: in_ready=1, out_valid=0. On accept: st<=din, cnt<=0, go to BUSY.
- BUSY: in_ready=0, out_valid=0, busy=1.
  - Each edge replaces bytes cnt*BPC .. cnt*BPC+BPC-1 of st with InvSbox(byte); cnt increments.
  - On the edge where cnt==NC-1, go to DONE and set out_valid<=1.
- DONE: out_valid=1; dout and out_valid are held stable while out_ready=0.
  - in_ready = out_ready (combinational), so input and output handshakes may occur on the same edge.
  - out_ready=1 and in_valid=1: new din is captured into st, cnt<=0, go to BUSY (back-to-back operation).
  - out_ready=1 and in_valid=0: go to IDLE; out_valid<=0.
- Timing: latency is NC+1 cycles from the accepting edge to the first cycle with out_valid=1 (5 cycles at BPC=4). Sustained throughput is one block per NC+1 cycles.
- dout is undefined-but-stable (no X) outside DONE: it shows the partially substituted st. Consumers qualify it with out_valid.
- in_valid while in_ready=0 is ignored; din is not sampled.
- The inverse S-box is a pure combinational 256-entry lookup per FIPS-197, instantiated BPC times. Spot values: 00->52, 01->09, 53->50, 63->00, 7C->01, ED->53, FF->7D.
- No arithmetic and no width growth; bytes are processed in ascending index order.

Test Plan:
- Reset, then din=0, in_valid=1 for one cycle -> in_ready drops; out_valid rises 5 cycles after the accept edge with dout=128'h52525252525252525252525252525252; busy high for exactly 4 cycles.
- din=128'h0F0E0D0C0B0A09080706050403020100 -> dout=128'hFBD7F3819EA340BF38A53630D56A0952.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises -> dout and out_valid stable throughout, in_ready=0; then out_ready=1 with in_valid=0 -> out_valid=0 next cycle, in_ready=1.
- Back-to-back: hold in_valid=1 and out_ready=1 with din=all 0x63, then all 0xED -> outputs all 0x00 then all 0x53; the second input is accepted on the same edge the first output is taken; one output every 5 cycles.
- Reset mid-operation: assert rst 2 cycles after accept -> out_valid stays 0, dout=0, in_ready=1 next cycle; the next block (din=all 0xFF) yields all 0x7D normally.
- Parameter sweep BPC=1, 2, 8, 16 with the second vector above -> identical dout; latency 17, 9, 3, 2 cycles respectively.
